// File: rtl/or_check_pkg.sv
// Shared types and constants for the OR-gate response checker.
package or_check_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  localparam int          DEF_WIDTH = 10;
  localparam int          DEF_ERR_W = 16;
endpackage

// File: rtl/or_check_misr.sv
// 16-bit serial MISR compressing the DUT response stream into a signature.
module or_check_misr
  import or_check_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed,
  input  logic        shift,
  input  logic        din,
  output logic [15:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (seed) begin
      sig <= MISR_SEED;
    end else if (shift) begin
      sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ din) ? MISR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/or_response_checker.sv
// On-chip verdict for an exhaustive OR-gate sweep: compares each response with |vec,
// counts mismatches and captures the first failing vector. Optional MISR: CHECKER_MISR_EN.
module or_response_checker
  import or_check_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] vec,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_vec,
  output logic [WIDTH:0]   checked_count
`ifdef CHECKER_MISR_EN
  ,
  output logic [15:0]      signature
`endif
);

  state_t           state_q, state_d;
  logic             start_ok, accept;
  logic             vld_p1, dut_p1, exp_p1, mis_p1;
  logic [WIDTH-1:0] vec_p1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  // Top bit of checked_count set means the full sweep has been accepted.
  assign accept   = (state_q == RUN) && vec_valid && !checked_count[WIDTH];
  assign mis_p1   = vld_p1 && (dut_p1 != exp_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (checked_count[WIDTH]) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: capture vector, response and expected value
  always_ff @(posedge clk) begin
    if (accept) begin
      vec_p1 <= vec;
      dut_p1 <= dut_out;
      exp_p1 <= |vec;
    end
  end

  // Stage 2: mismatch bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1          <= 1'b0;
      checked_count   <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (start_ok) begin
      vld_p1          <= 1'b0;
      checked_count   <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) checked_count <= checked_count + 1'b1;
      if (mis_p1) begin
        err_count <= sat_inc(err_count);
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= vec_p1;
        end
      end
    end
  end

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = (state_q == DONE);
  assign pass = done && (err_count == '0);

`ifdef CHECKER_MISR_EN
  or_check_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (start_ok),
    .shift (vld_p1),
    .din   (dut_p1),
    .sig   (signature)
  );
`endif

endmodule

// File: tb/tb_or_response_checker.sv
// Scoreboard bench for or_response_checker: directed sweeps, checked when done rises.
module tb_or_response_checker;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic [9:0] vec = '0;
  logic       dut_out = 1'b0;

  logic        busy_a, done_a, pass_a, fev_a;
  logic [15:0] err_a;
  logic [9:0]  fvec_a;
  logic [10:0] chk_a;
  logic        busy_b, done_b, pass_b, fev_b;
  logic [3:0]  err_b;
  logic [9:0]  fvec_b;
  logic [10:0] chk_b;
`ifdef CHECKER_MISR_EN
  logic [15:0] sig_a, sig_b;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          err;
    bit          fv;
    logic [9:0]  fvec;
    int          done_cyc;
    logic [15:0] sig;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  or_response_checker #(.WIDTH(10), .ERR_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_out(dut_out), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err_valid(fev_a), .first_err_vec(fvec_a),
    .checked_count(chk_a)
`ifdef CHECKER_MISR_EN
    , .signature(sig_a)
`endif
  );

  or_response_checker #(.WIDTH(10), .ERR_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_out(dut_out), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err_valid(fev_b), .first_err_vec(fvec_b),
    .checked_count(chk_b)
`ifdef CHECKER_MISR_EN
    , .signature(sig_b)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic resp(input int mode, input logic [9:0] v);
    case (mode)
      1:       return 1'b0;
      2:       return (|v) ^ (v == 10'h2A5);
      default: return |v;
    endcase
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_err"}, err_a, 0);
    chk({tag, "_fev"}, fev_a, 0);
    chk({tag, "_fvec"}, fvec_a, 0);
    chk({tag, "_checked"}, chk_a, 0);
    chk({tag, "_err_b"}, err_b, 0);
`ifdef CHECKER_MISR_EN
    chk({tag, "_sig"}, sig_a, 16'hFFFF);
`endif
  endtask

  // Monitor: one scoreboard entry per rising edge of done.
  bit done_q = 1'b0;
  always @(negedge clk) begin
    if (rst_n && done_a && !done_q) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("err_count", err_a, e.err);
        chk("err_count_sat4", err_b, (e.err > 15) ? 15 : e.err);
        chk("first_err_valid", fev_a, e.fv);
        chk("first_err_vec", fvec_a, e.fvec);
        chk("checked_count", chk_a, 1024);
        chk("pass", pass_a, e.err == 0);
        chk("busy_in_done", busy_a, 0);
`ifdef CHECKER_MISR_EN
        chk("signature", sig_a, e.sig);
        chk("signature_b", sig_b, e.sig);
`endif
      end
    end
    done_q = done_a;
  end

  task automatic sweep(input int mode, input int gap, input bit pulses,
                       input int exp_err, input bit exp_fv, input logic [9:0] exp_fvec);
    exp_t        e;
    logic [15:0] s;
    logic        d;
    int          t;
    s = 16'hFFFF;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int v = 0; v < 1024; v++) begin
      vec = v[9:0];
      d = resp(mode, vec);
      dut_out = d;
      vec_valid = 1'b1;
      s = {s[14:0], 1'b0} ^ ((s[15] ^ d) ? 16'h1021 : 16'h0000);
      if (v == 1023) begin
        e.err = exp_err; e.fv = exp_fv; e.fvec = exp_fvec;
        e.done_cyc = cyc + 3; e.sig = s;
        sb.push_back(e);
      end
      @(negedge clk);
      vec_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        start = pulses && (g == 0) && (v < 1000);
        @(negedge clk);
        start = 1'b0;
      end
    end
    t = 0;
    while (!done_a && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!done_a) chk("done_timeout", 0, 1);
    // vec_valid in DONE must not disturb held results
    vec_valid = 1'b1; vec = 10'h3FF; dut_out = 1'b0;
    repeat (3) @(negedge clk);
    vec_valid = 1'b0;
    chk("hold_done", done_a, 1);
    chk("hold_checked", chk_a, 1024);
    chk("hold_err", err_a, exp_err);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Partial faulty sweep aborted by reset
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int v = 0; v < 300; v++) begin
      vec = v[9:0]; dut_out = 1'b0; vec_valid = 1'b1;
      @(negedge clk);
    end
    vec_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", busy_a, 1);
    chk("pre_reset_checked", chk_a, 300);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    sweep(0, 0, 1'b0, 0,    1'b0, 10'h000);
    sweep(1, 0, 1'b0, 1023, 1'b1, 10'h001);
    sweep(2, 0, 1'b0, 1,    1'b1, 10'h2A5);
    sweep(0, 2, 1'b1, 0,    1'b0, 10'h000);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
